// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-descriptor to instruction-word encoder writing sequential IMEM words.
// Optional ENC_ALT_CHECK_EN: reject i_alt outside R funct3 0/5 and OP-IMM funct3 5 (error code 1).
module instr_encoder #(
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [3:0]        i_op,
  input  logic [2:0]        i_funct3,
  input  logic              i_alt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR} state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic              started_q;
  logic [3:0]        op_q;
  logic [2:0]        f3_q;
  logic              alt_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [31:0]       imm_q;
  logic [31:0]       word_q, word_d;
  logic              bad_op_q, bad_op_d;
  logic              bad_imm_q, bad_imm_d;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic accept, full, alt_ok, alt_eff, alt_bad, i_ok, b_ok, j_ok, shift_f3;

  assign full     = count_q[ADDR_W];
  assign o_rdy    = (state_q == S_IDLE) && started_q && !i_start;
  assign accept   = i_vld && o_rdy;
  assign o_imem_we = (state_q == S_WR) && !bad_op_q && !bad_imm_q && !full && !i_start;
  assign o_imem_addr  = BASE + count_q[ADDR_W-1:0];
  assign o_imem_wdata = word_q;
  assign o_count      = count_q;
  assign o_full       = full;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;

  // Sign-extension checks: the bits above the encodable field must all match.
  assign i_ok = (&imm_q[31:11]) || !(|imm_q[31:11]);
  assign b_ok = (&imm_q[31:12]) || !(|imm_q[31:12]);
  assign j_ok = (&imm_q[31:20]) || !(|imm_q[31:20]);
  assign shift_f3 = (f3_q == 3'd1) || (f3_q == 3'd5);

  assign alt_ok  = ((op_q == 4'd0) && ((f3_q == 3'd0) || (f3_q == 3'd5))) ||
                   ((op_q == 4'd1) && (f3_q == 3'd5));
  assign alt_eff = alt_q && alt_ok;
`ifdef ENC_ALT_CHECK_EN
  assign alt_bad = alt_q && !alt_ok;
`else
  assign alt_bad = 1'b0;
`endif

  always_comb begin
    word_d    = 32'h0;
    bad_op_d  = 1'b0;
    bad_imm_d = 1'b0;
    case (op_q)
      4'd0: word_d = {1'b0, alt_eff, 5'b0, rs2_q, rs1_q, f3_q, rd_q, 7'h33};
      4'd1: begin
        if (shift_f3) begin
          word_d    = {1'b0, alt_eff, 5'b0, imm_q[4:0], rs1_q, f3_q, rd_q, 7'h13};
          bad_imm_d = |imm_q[31:5];
        end else begin
          word_d    = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'h13};
          bad_imm_d = !i_ok;
        end
      end
      4'd2: begin
        word_d    = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'h03};
        bad_op_d  = (f3_q == 3'd3) || (f3_q >= 3'd6);
        bad_imm_d = !i_ok;
      end
      4'd3: begin
        word_d    = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'h23};
        bad_op_d  = f3_q > 3'd2;
        bad_imm_d = !i_ok;
      end
      4'd4: begin
        word_d    = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], 7'h63};
        bad_op_d  = (f3_q == 3'd2) || (f3_q == 3'd3);
        bad_imm_d = !b_ok || imm_q[0];
      end
      4'd5: begin
        word_d    = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'h6F};
        bad_imm_d = !j_ok || imm_q[0];
      end
      4'd6: begin
        word_d    = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'h67};
        bad_op_d  = f3_q != 3'd0;
        bad_imm_d = !i_ok;
      end
      4'd7: begin
        word_d    = {imm_q[31:12], rd_q, 7'h37};
        bad_imm_d = |imm_q[11:0];
      end
      4'd8: begin
        word_d    = {imm_q[31:12], rd_q, 7'h17};
        bad_imm_d = |imm_q[11:0];
      end
      default: bad_op_d = 1'b1;
    endcase
    if (alt_bad) bad_op_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ENC;
      S_ENC:   state_d = S_WR;
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_start) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      started_q  <= 1'b0;
      op_q       <= 4'h0;
      f3_q       <= 3'h0;
      alt_q      <= 1'b0;
      rd_q       <= 5'h0;
      rs1_q      <= 5'h0;
      rs2_q      <= 5'h0;
      imm_q      <= 32'h0;
      word_q     <= 32'h0;
      bad_op_q   <= 1'b0;
      bad_imm_q  <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (accept) begin
        op_q  <= i_op;
        f3_q  <= i_funct3;
        alt_q <= i_alt;
        rd_q  <= i_rd;
        rs1_q <= i_rs1;
        rs2_q <= i_rs2;
        imm_q <= i_imm;
      end
      if (state_q == S_ENC && !i_start) begin
        word_q    <= word_d;
        bad_op_q  <= bad_op_d;
        bad_imm_q <= bad_imm_d;
      end
      if (i_start) begin
        count_q    <= '0;
        err_q      <= 1'b0;
        err_code_q <= 2'd0;
      end else if (state_q == S_WR) begin
        if (o_imem_we) begin
          count_q <= count_q + ONE;
        end else begin
          // Only the first failure is recorded; later ones just keep the flag set.
          err_q <= 1'b1;
          if (!err_q) err_code_q <= bad_op_q ? 2'd1 : (bad_imm_q ? 2'd2 : 2'd3);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder (ADDR_W=2 so the full boundary is reachable).
module tb_instr_encoder;

  localparam int ADDR_W = 2;

  logic              clk, rst_n, start, vld, rdy;
  logic [3:0]        op;
  logic [2:0]        f3;
  logic              alt;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [ADDR_W:0]   count;
  logic              full, err;
  logic [1:0]        err_code;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;
  logic [63:0] exp_q[$];

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_vld(vld), .o_rdy(rdy),
    .i_op(op), .i_funct3(f3), .i_alt(alt), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_imm(imm), .o_imem_we(we), .o_imem_addr(addr), .o_imem_wdata(wdata),
    .o_count(count), .o_full(full), .o_err(err), .o_err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_val("wr_addr", 32'(addr), e[63:32]);
        check_val("wr_data", wdata, e[31:0]);
      end
    end
  end

  task automatic wait_rdy();
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) check_val("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input logic [3:0] o, input logic [2:0] f, input logic a, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    wait_rdy();
    op = o; f3 = f; alt = a; rd = d; rs1 = s1; rs2 = s2; imm = im;
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
  endtask

  task automatic send(input logic [3:0] o, input logic [2:0] f, input logic a, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                      input logic exp_we, input logic [31:0] exp_word);
    drive(o, f, a, d, s1, s2, im);
    if (exp_we) exp_q.push_back({32'(exp_count % (1 << ADDR_W)), exp_word});
    @(negedge clk);
    @(negedge clk);
    check_val("we_at_wr", 32'(we), 32'(exp_we));
    @(posedge clk);
    #1;
    if (exp_we) exp_count++;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_count = 0;
  endtask

  task automatic check_status(input string tag, input int c, input logic e, input logic [1:0] code);
    check_val({tag, "_count"}, 32'(count), 32'(c));
    check_val({tag, "_err"}, 32'(err), 32'(e));
    check_val({tag, "_code"}, 32'(err_code), 32'(code));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vld = 1'b0;
    op = '0; f3 = '0; alt = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    #12;
    check_val("rst_rdy", 32'(rdy), 32'd0);
    check_val("rst_we", 32'(we), 32'd0);
    check_val("rst_wdata", wdata, 32'd0);
    check_val("rst_full", 32'(full), 32'd0);
    check_status("rst", 0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("rdy_before_clk", 32'(rdy), 32'd0);

    send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    send(4'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b1, 32'h407302B3);
    check_status("add_sub", 2, 1'b0, 2'd0);
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
    check_status("addi_range", 3, 1'b1, 2'd2);

    pulse_start();
    check_status("start1", 0, 1'b0, 2'd0);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h00208463);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
    check_status("beq_odd", 1, 1'b1, 2'd2);
    send(4'd12, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
    check_status("code_kept", 1, 1'b1, 2'd2);

    pulse_start();
    send(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFFDFF0EF);
    send(4'd7, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h12345137);
    send(4'd12, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
    check_status("bad_op", 2, 1'b1, 2'd1);

    pulse_start();
    send(4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 1'b1, 32'h40315093);
    send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
    send(4'd7, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h12345137);
    check_val("full_set", 32'(full), 32'd1);
    check_status("fill", 4, 1'b0, 2'd0);
    send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0);
    check_status("overflow", 4, 1'b1, 2'd3);

    pulse_start();
    check_val("full_clear", 32'(full), 32'd0);
    check_status("start2", 0, 1'b0, 2'd0);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h00208463);

    // Abort during the write cycle.
    drive(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    #1 check_val("start_in_wr_we", 32'(we), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    exp_count = 0;
    check_status("start_in_wr", 0, 1'b0, 2'd0);

`ifdef ENC_ALT_CHECK_EN
    send(4'd1, 3'd0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0);
    check_status("alt_addi", 0, 1'b1, 2'd1);
`else
    send(4'd1, 3'd0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
    check_status("alt_addi", 1, 1'b0, 2'd0);
`endif

    // Async reset while in ENC.
    send(4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd64, 1'b0, 32'h0);
    drive(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_rdy", 32'(rdy), 32'd0);
    check_val("arst_we", 32'(we), 32'd0);
    check_val("arst_wdata", wdata, 32'd0);
    check_val("arst_full", 32'(full), 32'd0);
    check_status("arst", 0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    send(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    check_status("after_arst", 1, 1'b0, 2'd0);

    repeat (3) @(negedge clk);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
